// File: rtl/round_addr_sequencer_pkg.sv
// Shared AES round-key addressing constants and sequencer state encoding.
package round_addr_sequencer_pkg;

  // AES-128 uses rounds 0..10, so eleven round keys are addressed.
  localparam int unsigned NUM_ROUNDS   = 10;
  localparam int unsigned ROUND_ADDR_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } seq_state_e;

endpackage

// File: rtl/round_addr_sequencer_round_ctr.sv
// round_ctr: loadable up/down round counter with terminal-value compare.
// Stepping saturates at the terminal value, so it never wraps.
// Optional macro DECRYPT_EN enables the down-count direction; without it the
// counter only counts up and the down input is ignored.
module round_ctr
  import round_addr_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = round_addr_sequencer_pkg::NUM_ROUNDS,
  parameter int unsigned ADDR_W     = round_addr_sequencer_pkg::ROUND_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] count,
  output logic              at_term
);

  localparam logic [ADDR_W-1:0] TermHi = ADDR_W'(NUM_ROUNDS);
  localparam logic [ADDR_W-1:0] One    = ADDR_W'(1);

  logic [ADDR_W-1:0] count_q, count_d;

  // Terminal compare: top value when counting up, zero when counting down.
`ifdef DECRYPT_EN
  always_comb begin
    at_term = down ? (count_q == '0) : (count_q == TermHi);
  end
`else
  logic unused_down;
  assign unused_down = down;

  always_comb begin
    at_term = (count_q == TermHi);
  end
`endif

  // Next count: load has priority; a step at the terminal value is dropped.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (step && !at_term) begin
`ifdef DECRYPT_EN
      count_d = down ? (count_q - One) : (count_q + One);
`else
      count_d = count_q + One;
`endif
    end
  end

  // Count register, synchronously cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/round_addr_sequencer.sv
// round_addr_sequencer: emits the AES round-key address sequence 0..NUM_ROUNDS
// (or NUM_ROUNDS..0) one address per accepted valid/ready beat.
// Optional macro DECRYPT_EN honours the dir input for descending runs; without
// it dir is ignored and every run ascends.
module round_addr_sequencer
  import round_addr_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = round_addr_sequencer_pkg::NUM_ROUNDS,
  parameter int unsigned ADDR_W     = round_addr_sequencer_pkg::ROUND_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic              abort,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] TermHi = ADDR_W'(NUM_ROUNDS);

  seq_state_e        state_q, state_d;
  logic              dir_q, dir_d;
  logic              dir_in;
  logic              ctr_load;
  logic              ctr_step;
  logic [ADDR_W-1:0] ctr_load_val;
  logic              at_term;

`ifdef DECRYPT_EN
  assign dir_in = dir;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign dir_in     = 1'b0;
`endif

  round_ctr #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .ADDR_W     (ADDR_W)
  ) u_round_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .step     (ctr_step),
    .down     (dir_q),
    .count    (addr),
    .at_term  (at_term)
  );

  // Sequencer next-state: abort beats both start (in IDLE) and the final beat.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    ctr_load     = 1'b0;
    ctr_step     = 1'b0;
    ctr_load_val = dir_in ? TermHi : '0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d  = StRun;
          dir_d    = dir_in;
          ctr_load = 1'b1;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (addr_ready) begin
          if (at_term) begin
            state_d = StDone;
          end else begin
            ctr_step = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and latched direction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output.
  always_comb begin
    addr_valid = (state_q == StRun);
    last       = (state_q == StRun) && at_term;
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
  end

endmodule

// File: doc/round_addr_sequencer.md
# round_addr_sequencer

Generates the AES-128 round-key address sequence (0..10) that feeds the round-key storage select decoder, one address per accepted beat, under a valid/ready handshake. It sits between the top-level cipher control and the round-key storage address input. It paces key writes during expansion and key reads during cipher rounds. An optional descending mode serves the inverse cipher.

## Interface
Parameters:
- NUM_ROUNDS, default 10: terminal address for the ascending run; the sequence length is NUM_ROUNDS+1.
- ADDR_W, default 4: address width; must satisfy 2^ADDR_W > NUM_ROUNDS.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new sequence; sampled only in IDLE.
- dir  in  1  0 = ascending (0..NUM_ROUNDS), 1 = descending (NUM_ROUNDS..0); sampled with start.
- abort  in  1  cancel the sequence in progress.
- addr_ready  in  1  consumer accepts the current address.
- addr  out  ADDR_W  current round address.
- addr_valid  out  1  addr is valid.
- last  out  1  addr is the final address of the sequence; qualified by addr_valid.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- States:
  - IDLE: valid, busy and done low.
  - RUN: addr_valid high.
  - DONE: done high for exactly one cycle; addr_valid low.
- IDLE -> RUN when start=1 and abort=0.
  - addr is loaded with 0 (ascending) or NUM_ROUNDS (descending).
  - dir is latched for the whole run.
- In RUN, a beat is accepted when addr_valid && addr_ready.
  - Not last: addr steps +1 (ascending) or -1 (descending).
  - Last: go to DONE.
- last = (addr == NUM_ROUNDS) when ascending; (addr == 0) when descending.
- addr_valid and addr stay stable while addr_ready=0; no bubble is inserted between beats.
- DONE -> IDLE unconditionally on the next cycle.
- start outside IDLE is ignored. It is not queued.
- abort in RUN or DONE forces IDLE on the next cycle.
  - done does not pulse on an abort in RUN.
  - An abort coinciding with the final accepted beat wins: IDLE, no done.
- abort and start together in IDLE: abort wins; remain IDLE.
- The counter never wraps: it stops at the terminal value. Values above NUM_ROUNDS are never emitted.
- addr holds its last value in IDLE and DONE. Consumers must qualify addr with addr_valid.

## Timing
- Reset values: addr=0, addr_valid=0, last=0, busy=0, done=0, state IDLE, latched dir=0.
- Reset asserted mid-run returns to IDLE on the next edge, with no done.
- start sampled at edge N -> addr_valid=1 with the first address after edge N.
- With addr_ready held high, one address per cycle: 11 beats for NUM_ROUNDS=10.
  - done is high in the cycle after the last beat.
  - busy falls one cycle later still.
- Each cycle with addr_ready=0 in RUN delays completion by exactly one cycle.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- DECRYPT_EN defined: the dir input is honoured, and descending sequences are produced for the inverse cipher.
- DECRYPT_EN undefined: the dir port remains present but is ignored. The latched dir is forced to 0, so only ascending sequences are produced, and the descending-compare logic is removed.

## Structure
- The shared AES package holds:
  - the NUM_ROUNDS constant (10);
  - ROUND_ADDR_W (4);
  - the sequencer state enum (IDLE, RUN, DONE).
- One natural sub-module: round_ctr.
  - Loadable up/down counter with a terminal-compare output.
  - The FSM lives in round_addr_sequencer.

## Test plan
- Ascending, addr_ready tied high: pulse start with dir=0.
  - Required: addr 0,1,…,10 on consecutive cycles; last only with addr=10; done one cycle later; busy low after that.
- Backpressure: drop addr_ready at addr=4 for 3 cycles.
  - Required: addr stays 4 with valid high throughout; sequence resumes at 5; done is delayed by 3 cycles.
- Descending, with DECRYPT_EN: start with dir=1.
  - Required: addr 10,9,…,0; last with addr=0.
  - Without the macro, the same stimulus yields 0..10.
- Abort at addr=6 in RUN.
  - Required: valid low next cycle; done never pulses; a new start then begins at 0.
- Robustness:
  - start while busy is ignored.
  - start together with abort in IDLE stays IDLE.
  - rst asserted at addr=3 gives all outputs 0 next cycle.
